final_link_tx_scheduler: RTL and testbench
==========================================

Name: final_link_tx_scheduler

Overview:
- Shares the single physical inter-FPGA transmit FIFO among FIFO_COUNT master FIFOs plus the spanning-controller (sc) FIFO.
- Grants one requester per cycle round-robin, packs the payload with its source index into a registered output word, and enforces credit-based flow control toward the remote hub.
- Sits between the per-row master FIFO / sc FIFO outputs and final_fifo_out of the hub.
- Reports has_flying_messages for the convergence detector.

Parameters:
- HUB_FIFO_WIDTH, 13, logical payload width per requester.
- HUB_FIFO_PHYSICAL_WIDTH, 128, physical link word width.
- FIFO_IDWIDTH, 2, source-index field width; must satisfy 2^FIFO_IDWIDTH >= FIFO_COUNT+1.
- FIFO_COUNT, 3, number of master FIFOs. Total requesters N = FIFO_COUNT+1; sc is index FIFO_COUNT.
- CREDIT_COUNT, 8, remote receive slots. Counter width is $clog2(CREDIT_COUNT+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- master_fifo_out_data_vector  in  HUB_FIFO_WIDTH*FIFO_COUNT  payload i at [i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH]
- master_fifo_out_valid_vector  in  FIFO_COUNT  request per master FIFO
- master_fifo_out_ready_vector  out  FIFO_COUNT  pop strobe, one-hot or zero
- sc_fifo_out_data  in  HUB_FIFO_WIDTH  sc payload
- sc_fifo_out_valid  in  1  sc request
- sc_fifo_out_ready  out  1  sc pop strobe
- final_fifo_out_data  out  HUB_FIFO_PHYSICAL_WIDTH  packed link word
- final_fifo_out_valid  out  1  link word valid
- final_fifo_out_ready  in  1  link accepts word
- credit_return  in  1  one-cycle pulse; remote freed one slot
- credits_available  out  $clog2(CREDIT_COUNT+1)  current credit count
- credit_error  out  1  sticky; credit returned while the counter was already full
- has_flying_messages  out  1  traffic pending or in flight

Behaviour:
- Reset (asynchronous, active-high). All outputs and state are cleared immediately:
  - final_fifo_out_valid = 0, final_fifo_out_data = 0
  - rr_ptr = 0, credits = CREDIT_COUNT, credit_error = 0
  - all ready outputs = 0
  - Reset mid-transfer drops the held word; the requester has already popped it, so it is lost by design.
- Requests: req[i] = master valid i for i < FIFO_COUNT; req[FIFO_COUNT] = sc_fifo_out_valid.
- can_load = (!final_fifo_out_valid || final_fifo_out_ready) && credits != 0.
- Grant (combinational):
  - When can_load and any req is set, grant the first set req searching from rr_ptr upward, wrapping modulo N.
  - The granted requester's ready is asserted in the same cycle. All other readies are 0.
  - Readies are 0 whenever can_load = 0.
- Load, at the clock edge following a grant:
  - Output register is written:
    - data[HUB_FIFO_WIDTH-1:0] = payload
    - data[HUB_FIFO_WIDTH +: FIFO_IDWIDTH] = grant index
    - remaining upper bits = 0
  - final_fifo_out_valid = 1.
  - rr_ptr = (grant index + 1) mod N.
  - Latency: request to output valid is 1 cycle.
- Drain:
  - If valid && ready and there is no grant this cycle, valid falls to 0.
  - Sustained throughput is 1 word per cycle while ready = 1 and credits remain.
- Hold: while valid && !ready, the data word is stable and no grants are issued.
- Credits:
  - A grant decrements the counter.
  - credit_return increments the counter.
  - Grant and return in the same cycle: counter unchanged.
  - Return while credits == CREDIT_COUNT and no grant: counter saturates and credit_error is set (sticky until reset).
  - With credits == 0, no grant is issued; a return in that cycle enables a grant from the next cycle.
- Idle: rr_ptr is unchanged when there is no grant.
- has_flying_messages = final_fifo_out_valid | (credits != CREDIT_COUNT) | (|req). Purely combinational from registers and inputs.

Optional Feature:
- Macro FINAL_ARB_SC_PRIORITY_EN.
- Defined:
  - The sc requester has strict priority: whenever sc_fifo_out_valid and can_load, sc is granted.
  - Master FIFOs are round-robin among themselves only (modulo FIFO_COUNT).
  - rr_ptr is updated only on master grants.
- Undefined: sc is an ordinary round-robin participant as described in Behaviour.

Test Plan:
- Single request: reset, then master 1 valid with payload 0x0A5, ready = 1.
  - master_fifo_out_ready_vector = 3'b010 in cycle 0.
  - Cycle 1: valid = 1, data[12:0] = 0x0A5, data[14:13] = 1.
  - credits_available = 7.
- Fairness: all 4 requesters valid continuously, ready = 1, credit_return every cycle. Grant order is 0,1,2,3,0,1,… with exactly one ready per cycle and no starvation.
- Backpressure: load a word from master 2, then hold ready = 0 for 5 cycles with all requesters valid.
  - Data is stable and all readies are 0.
  - When ready returns, the next grant is index 3 in the same cycle.
- Credit exhaustion: master 0 always valid, ready = 1, no returns.
  - Exactly 8 words are sent, then credits_available = 0 and readies are 0.
  - One credit_return pulse leads to exactly one more word.
  - has_flying_messages stays 1 throughout.
- Credit error and idle: with credits == 8, pulse credit_return → credit_error = 1 and it stays set. After reset → credit_error = 0 and has_flying_messages = 0 with no requests.
- Reset mid-hold: word held with ready = 0, assert reset asynchronously between edges. final_fifo_out_valid drops immediately, credits = 8, rr_ptr = 0 (next grant with all valid is index 0).
- Macro defined: sc and masters 0–2 all valid. sc is granted every cycle while valid. After sc deasserts, masters are granted in order 0,1,2.

Source files
------------

// File: rtl/final_link_tx_scheduler.sv
// Round-robin scheduler sharing the inter-FPGA transmit FIFO among master FIFOs and the sc FIFO,
// with credit-based flow control. Optional macro FINAL_ARB_SC_PRIORITY_EN gives sc strict priority.
module final_link_tx_scheduler #(
  parameter int HUB_FIFO_WIDTH          = 13,
  parameter int HUB_FIFO_PHYSICAL_WIDTH = 128,
  parameter int FIFO_IDWIDTH            = 2,
  parameter int FIFO_COUNT              = 3,
  parameter int CREDIT_COUNT            = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [HUB_FIFO_WIDTH*FIFO_COUNT-1:0]   master_fifo_out_data_vector,
  input  logic [FIFO_COUNT-1:0]                  master_fifo_out_valid_vector,
  output logic [FIFO_COUNT-1:0]                  master_fifo_out_ready_vector,
  input  logic [HUB_FIFO_WIDTH-1:0]              sc_fifo_out_data,
  input  logic                                   sc_fifo_out_valid,
  output logic                                   sc_fifo_out_ready,
  output logic [HUB_FIFO_PHYSICAL_WIDTH-1:0]     final_fifo_out_data,
  output logic                                   final_fifo_out_valid,
  input  logic                                   final_fifo_out_ready,
  input  logic                                   credit_return,
  output logic [$clog2(CREDIT_COUNT+1)-1:0]      credits_available,
  output logic                                   credit_error,
  output logic                                   has_flying_messages
);

  localparam int unsigned N  = FIFO_COUNT + 1;
  localparam int          CW = $clog2(CREDIT_COUNT + 1);

  logic [N-1:0]                       req;
  logic [FIFO_IDWIDTH-1:0]            rr_ptr, rr_ptr_next;
  logic [CW-1:0]                      credits;
  logic                               can_load;
  logic                               grant_valid;
  logic [FIFO_IDWIDTH-1:0]            grant_idx;
  logic [HUB_FIFO_WIDTH-1:0]          payload;
  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] load_word;
  int unsigned                        base, idx;

  assign req      = {sc_fifo_out_valid, master_fifo_out_valid_vector};
  // Gating with reset keeps every pop strobe low while reset is held
  assign can_load = !reset && (!final_fifo_out_valid || final_fifo_out_ready) && (credits != '0);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_ptr_next = rr_ptr;
    base        = 32'(rr_ptr);
    idx         = 0;
    if (can_load) begin
`ifdef FINAL_ARB_SC_PRIORITY_EN
      if (sc_fifo_out_valid) begin
        grant_valid = 1'b1;
        grant_idx   = FIFO_IDWIDTH'(FIFO_COUNT);
      end else begin
        for (int unsigned k = 0; k < FIFO_COUNT; k++) begin
          idx = (base + k) % FIFO_COUNT;
          for (int unsigned j = 0; j < FIFO_COUNT; j++) begin
            if (!grant_valid && j == idx && req[j]) begin
              grant_valid = 1'b1;
              grant_idx   = FIFO_IDWIDTH'(j);
              rr_ptr_next = FIFO_IDWIDTH'((j + 1) % FIFO_COUNT);
            end
          end
        end
      end
`else
      for (int unsigned k = 0; k < N; k++) begin
        idx = (base + k) % N;
        for (int unsigned j = 0; j < N; j++) begin
          if (!grant_valid && j == idx && req[j]) begin
            grant_valid = 1'b1;
            grant_idx   = FIFO_IDWIDTH'(j);
            rr_ptr_next = FIFO_IDWIDTH'((j + 1) % N);
          end
        end
      end
`endif
    end
  end

  always_comb begin
    master_fifo_out_ready_vector = '0;
    sc_fifo_out_ready            = grant_valid && (grant_idx == FIFO_IDWIDTH'(FIFO_COUNT));
    payload                      = sc_fifo_out_data;
    for (int unsigned i = 0; i < FIFO_COUNT; i++) begin
      if (grant_idx == FIFO_IDWIDTH'(i)) begin
        master_fifo_out_ready_vector[i] = grant_valid;
        payload = master_fifo_out_data_vector[i*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
      end
    end
    load_word                                  = '0;
    load_word[HUB_FIFO_WIDTH-1:0]              = payload;
    load_word[HUB_FIFO_WIDTH +: FIFO_IDWIDTH]  = grant_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      final_fifo_out_valid <= 1'b0;
      final_fifo_out_data  <= '0;
      rr_ptr               <= '0;
    end else if (grant_valid) begin
      final_fifo_out_valid <= 1'b1;
      final_fifo_out_data  <= load_word;
      rr_ptr               <= rr_ptr_next;
    end else if (final_fifo_out_ready) begin
      final_fifo_out_valid <= 1'b0;
    end
  end

  // Simultaneous grant and return cancel; a return into a full counter saturates and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits      <= CW'(CREDIT_COUNT);
      credit_error <= 1'b0;
    end else begin
      case ({grant_valid, credit_return})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CW'(CREDIT_COUNT)) credit_error <= 1'b1;
          else                              credits      <= credits + 1'b1;
        end
        default: credits <= credits;
      endcase
    end
  end

  assign credits_available   = credits;
  assign has_flying_messages = final_fifo_out_valid | (credits != CW'(CREDIT_COUNT)) | (|req);

endmodule

// File: tb/tb_final_link_tx_scheduler.sv
// Directed self-checking bench for final_link_tx_scheduler.
module tb_final_link_tx_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [38:0]  master_fifo_out_data_vector;
  logic [2:0]   master_fifo_out_valid_vector;
  logic [2:0]   master_fifo_out_ready_vector;
  logic [12:0]  sc_fifo_out_data;
  logic         sc_fifo_out_valid;
  logic         sc_fifo_out_ready;
  logic [127:0] final_fifo_out_data;
  logic         final_fifo_out_valid;
  logic         final_fifo_out_ready;
  logic         credit_return;
  logic [3:0]   credits_available;
  logic         credit_error;
  logic         has_flying_messages;

  int checks = 0;
  int errors = 0;

  final_link_tx_scheduler #(
    .HUB_FIFO_WIDTH(13), .HUB_FIFO_PHYSICAL_WIDTH(128), .FIFO_IDWIDTH(2),
    .FIFO_COUNT(3), .CREDIT_COUNT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .master_fifo_out_data_vector(master_fifo_out_data_vector),
    .master_fifo_out_valid_vector(master_fifo_out_valid_vector),
    .master_fifo_out_ready_vector(master_fifo_out_ready_vector),
    .sc_fifo_out_data(sc_fifo_out_data), .sc_fifo_out_valid(sc_fifo_out_valid),
    .sc_fifo_out_ready(sc_fifo_out_ready),
    .final_fifo_out_data(final_fifo_out_data), .final_fifo_out_valid(final_fifo_out_valid),
    .final_fifo_out_ready(final_fifo_out_ready), .credit_return(credit_return),
    .credits_available(credits_available), .credit_error(credit_error),
    .has_flying_messages(has_flying_messages)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] word(input logic [12:0] p, input logic [1:0] id);
    logic [127:0] w;
    w = '0;
    w[12:0]  = p;
    w[14:13] = id;
    return w;
  endfunction

  task automatic set_payloads();
    master_fifo_out_data_vector = {13'h0C02, 13'h0B01, 13'h0A00};
    sc_fifo_out_data            = 13'h1D03;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    master_fifo_out_valid_vector = '0;
    sc_fifo_out_valid    = 1'b0;
    final_fifo_out_ready = 1'b0;
    credit_return        = 1'b0;
    set_payloads();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_payloads();
    master_fifo_out_valid_vector = 3'b111;
    sc_fifo_out_valid    = 1'b1;
    final_fifo_out_ready = 1'b1;
    credit_return        = 1'b0;
    #2;
    checks++;
    if (final_fifo_out_valid !== 1'b0 || final_fifo_out_data !== '0) begin
      errors++; $display("FAIL reset_out valid=%b data=%h req 0/0", final_fifo_out_valid, final_fifo_out_data);
    end
    checks++;
    if (credits_available !== 4'd8 || credit_error !== 1'b0) begin
      errors++; $display("FAIL reset_credits credits=%0d err=%b req 8/0", credits_available, credit_error);
    end
    checks++;
    if (master_fifo_out_ready_vector !== 3'b000 || sc_fifo_out_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready m=%b sc=%b req 000/0", master_fifo_out_ready_vector, sc_fifo_out_ready);
    end
    do_reset();
    checks++;
    if (has_flying_messages !== 1'b0) begin
      errors++; $display("FAIL reset_flying got=%b req 0", has_flying_messages);
    end
  endtask

  task automatic test_single();
    do_reset();
    master_fifo_out_data_vector[25:13] = 13'h0A5;
    master_fifo_out_valid_vector = 3'b010;
    final_fifo_out_ready = 1'b1;
    #1;
    checks++;
    if (master_fifo_out_ready_vector !== 3'b010 || sc_fifo_out_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready m=%b req 010", master_fifo_out_ready_vector);
    end
    step();
    master_fifo_out_valid_vector = 3'b000;
    checks++;
    if (final_fifo_out_valid !== 1'b1 || final_fifo_out_data !== word(13'h0A5, 2'd1)) begin
      errors++; $display("FAIL single_word valid=%b data=%h req 1/%h", final_fifo_out_valid, final_fifo_out_data, word(13'h0A5, 2'd1));
    end
    checks++;
    if (credits_available !== 4'd7) begin
      errors++; $display("FAIL single_credits got=%0d req 7", credits_available);
    end
    step();
    checks++;
    if (final_fifo_out_valid !== 1'b0 || credits_available !== 4'd7) begin
      errors++; $display("FAIL single_drain valid=%b credits=%0d req 0/7", final_fifo_out_valid, credits_available);
    end
  endtask

  task automatic test_fairness();
    logic [12:0] pay [4];
    pay[0] = 13'h0A00; pay[1] = 13'h0B01; pay[2] = 13'h0C02; pay[3] = 13'h1D03;
    do_reset();
    master_fifo_out_valid_vector = 3'b111;
    sc_fifo_out_valid    = 1'b1;
    final_fifo_out_ready = 1'b1;
    credit_return        = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++;
      if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== (4'b0001 << (c % 4))) begin
        errors++; $display("FAIL fair_ready cycle=%0d got=%b req=%b", c,
                           {sc_fifo_out_ready, master_fifo_out_ready_vector}, 4'b0001 << (c % 4));
      end
      step();
      checks++;
      if (final_fifo_out_valid !== 1'b1 || final_fifo_out_data !== word(pay[c % 4], 2'(c % 4))) begin
        errors++; $display("FAIL fair_word cycle=%0d got=%h req=%h", c, final_fifo_out_data, word(pay[c % 4], 2'(c % 4)));
      end
    end
    checks++;
    if (credits_available !== 4'd8 || credit_error !== 1'b0) begin
      errors++; $display("FAIL fair_credits credits=%0d err=%b req 8/0", credits_available, credit_error);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    master_fifo_out_valid_vector = 3'b100;
    final_fifo_out_ready = 1'b1;
    step();
    master_fifo_out_valid_vector = 3'b111;
    sc_fifo_out_valid    = 1'b1;
    final_fifo_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== 4'b0000) begin
        errors++; $display("FAIL bp_ready cycle=%0d got=%b req 0000", c, {sc_fifo_out_ready, master_fifo_out_ready_vector});
      end
      step();
      checks++;
      if (final_fifo_out_valid !== 1'b1 || final_fifo_out_data !== word(13'h0C02, 2'd2)) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%h req=%h", c, final_fifo_out_data, word(13'h0C02, 2'd2));
      end
    end
    final_fifo_out_ready = 1'b1;
    #1;
    checks++;
    if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== 4'b1000) begin
      errors++; $display("FAIL bp_resume got=%b req 1000", {sc_fifo_out_ready, master_fifo_out_ready_vector});
    end
    step();
    checks++;
    if (final_fifo_out_data !== word(13'h1D03, 2'd3) || credits_available !== 4'd6) begin
      errors++; $display("FAIL bp_next data=%h credits=%0d req %h/6", final_fifo_out_data, credits_available, word(13'h1D03, 2'd3));
    end
  endtask

  task automatic test_credit_exhaust();
    int sent = 0;
    int flying_bad = 0;
    do_reset();
    master_fifo_out_valid_vector = 3'b001;
    final_fifo_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (master_fifo_out_ready_vector[0] === 1'b1) sent++;
      if (has_flying_messages !== 1'b1) flying_bad++;
      step();
    end
    checks++;
    if (sent != 8 || credits_available !== 4'd0 || master_fifo_out_ready_vector !== 3'b000) begin
      errors++; $display("FAIL exhaust sent=%0d credits=%0d ready=%b req 8/0/000", sent, credits_available, master_fifo_out_ready_vector);
    end
    credit_return = 1'b1;
    #1;
    checks++;
    if (master_fifo_out_ready_vector !== 3'b000) begin
      errors++; $display("FAIL exhaust_return_cycle ready=%b req 000", master_fifo_out_ready_vector);
    end
    if (has_flying_messages !== 1'b1) flying_bad++;
    step();
    credit_return = 1'b0;
    checks++;
    if (credits_available !== 4'd1) begin
      errors++; $display("FAIL exhaust_credit got=%0d req 1", credits_available);
    end
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (master_fifo_out_ready_vector[0] === 1'b1) sent++;
      if (has_flying_messages !== 1'b1) flying_bad++;
      step();
    end
    checks++;
    if (sent != 1 || credits_available !== 4'd0) begin
      errors++; $display("FAIL exhaust_one_more sent=%0d credits=%0d req 1/0", sent, credits_available);
    end
    checks++;
    if (flying_bad != 0) begin
      errors++; $display("FAIL exhaust_flying low_cycles=%0d req 0", flying_bad);
    end
  endtask

  task automatic test_credit_error();
    do_reset();
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    checks++;
    if (credit_error !== 1'b1 || credits_available !== 4'd8) begin
      errors++; $display("FAIL cerr_set err=%b credits=%0d req 1/8", credit_error, credits_available);
    end
    step(); step();
    checks++;
    if (credit_error !== 1'b1) begin
      errors++; $display("FAIL cerr_sticky err=%b req 1", credit_error);
    end
    do_reset();
    checks++;
    if (credit_error !== 1'b0 || has_flying_messages !== 1'b0) begin
      errors++; $display("FAIL cerr_clear err=%b flying=%b req 0/0", credit_error, has_flying_messages);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    master_fifo_out_valid_vector = 3'b010;
    step();
    master_fifo_out_valid_vector = 3'b111;
    sc_fifo_out_valid = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (final_fifo_out_valid !== 1'b0 || credits_available !== 4'd8) begin
      errors++; $display("FAIL midreset valid=%b credits=%0d req 0/8", final_fifo_out_valid, credits_available);
    end
    reset = 1'b0;
    final_fifo_out_ready = 1'b1;
    #1;
    checks++;
    if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== 4'b0001) begin
      errors++; $display("FAIL midreset_ptr got=%b req 0001", {sc_fifo_out_ready, master_fifo_out_ready_vector});
    end
    step();
  endtask

`ifdef FINAL_ARB_SC_PRIORITY_EN
  task automatic test_sc_priority();
    do_reset();
    master_fifo_out_valid_vector = 3'b111;
    sc_fifo_out_valid    = 1'b1;
    final_fifo_out_ready = 1'b1;
    credit_return        = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== 4'b1000) begin
        errors++; $display("FAIL prio_sc cycle=%0d got=%b req 1000", c, {sc_fifo_out_ready, master_fifo_out_ready_vector});
      end
      step();
    end
    sc_fifo_out_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({sc_fifo_out_ready, master_fifo_out_ready_vector} !== (4'b0001 << c)) begin
        errors++; $display("FAIL prio_master cycle=%0d got=%b req=%b", c, {sc_fifo_out_ready, master_fifo_out_ready_vector}, 4'b0001 << c);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_credit_exhaust();
    test_credit_error();
    test_reset_mid_hold();
`ifdef FINAL_ARB_SC_PRIORITY_EN
    test_sc_priority();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
